// File: rtl/resp_pipe.sv
// Return-path FIFO from the responder (front) to the initiator (back), with a sticky front-side protocol checker.
// One cycle of latency; ready_f depends only on occupancy. RESP_PIPE_BYPASS_EN adds a zero-latency path while the FIFO is empty.
module resp_pipe #(
  parameter int L     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_f,
  output logic          ready_f,
  input  logic [L-1:0]  data_f,
  output logic          valid_b,
  input  logic          ready_b,
  output logic [L-1:0]  data_b,
  output logic [AW:0]   count,
  output logic          proto_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [L-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          stall_q;
  logic [L-1:0]  data_q;
  logic          empty;
  logic          full;
  logic          push;
  logic          wr_en;
  logic          rd_en;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign ready_f = rst & ~full;
  assign push    = valid_f & ready_f;

`ifdef RESP_PIPE_BYPASS_EN
  // While empty, the front word is shown directly; it is stored only if the back stalls.
  assign valid_b = empty ? (valid_f & rst) : 1'b1;
  assign data_b  = !valid_b ? '0 : (empty ? data_f : mem[rd_ptr]);
  assign wr_en   = push & ~(empty & ready_b);
`else
  assign valid_b = ~empty;
  assign data_b  = valid_b ? mem[rd_ptr] : '0;
  assign wr_en   = push;
`endif

  assign rd_en = valid_b & ready_b & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_f;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      stall_q   <= 1'b0;
      data_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A stalled offer must stay valid with unchanged data until it is taken.
      stall_q <= valid_f & ~ready_f;
      data_q  <= data_f;
      if (stall_q && (!valid_f || (data_f != data_q))) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_resp_pipe.sv
// Directed bench for resp_pipe (DEPTH=4, L=8) with a scoreboard queue fed by observed front handshakes.
module tb_resp_pipe;
  localparam int L     = 8;
  localparam int DEPTH = 4;

  logic         clk     = 1'b0;
  logic         rst     = 1'b0;
  logic         valid_f = 1'b0;
  logic         ready_f;
  logic [L-1:0] data_f  = '0;
  logic         valid_b;
  logic         ready_b = 1'b0;
  logic [L-1:0] data_b;
  logic [2:0]   count;
  logic         proto_err;

  int passed  = 0;
  int failed  = 0;
  int total   = 0;
  int pops    = 0;
  int max_cnt = 0;
  logic [L-1:0] exp_q[$];

  resp_pipe #(.L(L), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .valid_f(valid_f), .ready_f(ready_f), .data_f(data_f),
    .valid_b(valid_b), .ready_b(ready_b), .data_b(data_b),
    .count(count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted front words, compare every back transfer.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (valid_f && ready_f) exp_q.push_back(data_f);
      if (valid_b && ready_b) begin
        pops++;
        check("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_data", 32'(data_b), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    int budget;
    logic accepted;

    // Reset state
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_ready_f", 32'(ready_f), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("ready_after_rst", 32'(ready_f), 32'd1);

    // Single word A5 with the back side ready
    valid_f = 1'b1; data_f = 8'hA5; ready_b = 1'b1;
    #1;
`ifdef RESP_PIPE_BYPASS_EN
    check("byp_valid_b", 32'(valid_b), 32'd1);
    check("byp_data_b", 32'(data_b), 32'hA5);
    next();
    valid_f = 1'b0;
    #1 check("byp_count", 32'(count), 32'd0);
`else
    check("a5_not_early", 32'(valid_b), 32'd0);
    next();
    valid_f = 1'b0;
    #1;
    check("a5_count1", 32'(count), 32'd1);
    check("a5_valid_b", 32'(valid_b), 32'd1);
    check("a5_data_b", 32'(data_b), 32'hA5);
    next();
    #1;
    check("a5_count0", 32'(count), 32'd0);
    check("a5_valid_gone", 32'(valid_b), 32'd0);
`endif

    // Fill to full with the back stalled, fifth word held off
    ready_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      valid_f = 1'b1; data_f = 8'(k);
      next();
    end
    data_f = 8'h05;
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_ready_f", 32'(ready_f), 32'd0);
    next();
    next();
    #1;
    check("held_count", 32'(count), 32'd4);
    check("held_proto_err", 32'(proto_err), 32'd0);
    ready_b = 1'b1;
    next();
    #1;
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_ready_f", 32'(ready_f), 32'd1);
    next();
    valid_f = 1'b0;
    #1 check("pushpop_count", 32'(count), 32'd3);
    repeat (3) next();
    #1;
    check("drain_count", 32'(count), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stream 20 words with random back-side stalls
    i = 0;
    budget = 0;
    while (i < 20 && budget < 1000) begin
      valid_f = 1'b1;
      data_f  = 8'h10 + 8'(i);
      ready_b = 1'($urandom_range(0, 1));
      #1 accepted = ready_f;
      next();
      if (accepted) i++;
      budget++;
    end
    valid_f = 1'b0;
    ready_b = 1'b1;
    check("stream_all_sent", 32'(i), 32'd20);
    for (int k = 0; k < 20 && count != 0; k++) next();
    #1;
    check("stream_drained", 32'(count), 32'd0);
    check("stream_sb_empty", 32'(exp_q.size()), 32'd0);
    check("stream_max_count_ok", 32'(max_cnt <= DEPTH), 32'd1);
    check("stream_pops", 32'(pops), 32'd26);
    check("stream_proto_err", 32'(proto_err), 32'd0);

    // Withdrawn offer while full
    ready_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_f = 1'b1; data_f = 8'h31 + 8'(k);
      next();
    end
    data_f = 8'h35;
    next();
    valid_f = 1'b0;
    #1 check("withdraw_before", 32'(proto_err), 32'd0);
    next();
    #1 check("withdraw_set", 32'(proto_err), 32'd1);
    next();
    next();
    #1 check("withdraw_sticky", 32'(proto_err), 32'd1);
    rst = 1'b0;
    #1;
    check("withdraw_rst_clear", 32'(proto_err), 32'd0);
    check("withdraw_rst_count", 32'(count), 32'd0);
    exp_q.delete();
    next();
    rst = 1'b1;

    // Data changed while stalled
    for (int k = 0; k < 4; k++) begin
      valid_f = 1'b1; data_f = 8'h41 + 8'(k);
      next();
    end
    data_f = 8'h45;
    next();
    data_f = 8'h46;
    #1 check("datachg_before", 32'(proto_err), 32'd0);
    next();
    #1 check("datachg_set", 32'(proto_err), 32'd1);
    valid_f = 1'b0;
    rst = 1'b0;
    #1;
    exp_q.delete();
    next();
    rst = 1'b1;

    // Asynchronous reset with three stored words
    ready_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_f = 1'b1; data_f = 8'h51 + 8'(k);
      next();
    end
    valid_f = 1'b0;
    #1 check("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid_b", 32'(valid_b), 32'd0);
    check("async_rst_data_b", 32'(data_b), 32'd0);
    exp_q.delete();
    next();
    rst = 1'b1;
    valid_f = 1'b1; data_f = 8'h7E; ready_b = 1'b1;
    next();
    valid_f = 1'b0;
    #1;
`ifndef RESP_PIPE_BYPASS_EN
    check("post_rst_valid_b", 32'(valid_b), 32'd1);
    check("post_rst_data_b", 32'(data_b), 32'h7E);
`endif
    next();
    #1;
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_valid_gone", 32'(valid_b), 32'd0);
    check("total_pops", 32'(pops), 32'd27);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
